// File: rtl/ec_jb_point_dbl_seq.sv
// Sequential Jacobian point doubler (a=0 short-Weierstrass) over a shared modular multiplier.
// Computes A=Y^2, B=4XA, C=8A^2, D=3X^2, X3=D^2-2B, Y3=D(B-X3)-C, Z3=2YZ with 7 multiplies.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_pt/i_val/o_rdy        input point {x,y,z} handshake
//   o_pt/o_val/i_rdy        doubled point {x,y,z} handshake
//   o_mul_a/o_mul_b/o_mul_val/i_mul_rdy   multiplier request
//   i_mul_c/i_mul_val       multiplier result (in order, latency >= 1)
// Configuration macro: EC_DBL_ZERO_BYPASS_EN -- when defined, an input with z==0 is
//   returned unchanged one cycle after accept with no multiplier traffic.
module ec_jb_point_dbl_seq #(
    parameter int unsigned          DAT_BITS = 381,
    parameter logic [DAT_BITS-1:0]  P        = DAT_BITS'(381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3*DAT_BITS-1:0]   i_pt,
    input  logic                    i_val,
    output logic                    o_rdy,
    output logic [3*DAT_BITS-1:0]   o_pt,
    output logic                    o_val,
    input  logic                    i_rdy,
    output logic [DAT_BITS-1:0]     o_mul_a,
    output logic [DAT_BITS-1:0]     o_mul_b,
    output logic                    o_mul_val,
    input  logic                    i_mul_rdy,
    input  logic [DAT_BITS-1:0]     i_mul_c,
    input  logic                    i_mul_val
);

    localparam int unsigned W = DAT_BITS;
    localparam logic [2:0] LAST_STEP = 3'd6;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, POST, DONE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     step;
    logic [W-1:0]   x, y, z, a, b, c, d, r1, r2, res;
    logic [W-1:0]   x3, y3, z3;
    logic [W-1:0]   x3_new;

    // (a + b) mod P, inputs < P, sum fits in W+1 bits
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] p, input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, p} + {1'b0, q};
        if (s >= {1'b0, P})
            s = s - {1'b0, P};
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_dbl(input logic [W-1:0] p);
        return mod_add(p, p);
    endfunction

    // (a - b) mod P, wrap by adding P when a < b
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] p, input logic [W-1:0] q);
        logic [W:0] s;
        if (p >= q)
            s = {1'b0, p} - {1'b0, q};
        else
            s = {1'b0, p} + {1'b0, P} - {1'b0, q};
        return W'(s);
    endfunction

`ifdef EC_DBL_ZERO_BYPASS_EN
    logic zin_zero;
    assign zin_zero = (i_pt[W-1:0] == '0);
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_val) begin
`ifdef EC_DBL_ZERO_BYPASS_EN
                    state_nxt = zin_zero ? DONE : ISSUE;
`else
                    state_nxt = ISSUE;
`endif
                end
            end
            ISSUE:   if (i_mul_rdy) state_nxt = WAIT;
            WAIT:    if (i_mul_val) state_nxt = POST;
            POST:    state_nxt = (step < LAST_STEP) ? ISSUE : DONE;
            DONE:    if (i_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register; operands selected by step
    always_comb begin
        o_rdy     = (state == IDLE);
        o_val     = (state == DONE);
        o_mul_val = (state == ISSUE);
        o_mul_a   = '0;
        o_mul_b   = '0;
        if (state == ISSUE) begin
            case (step)
                3'd0:    begin o_mul_a = y;  o_mul_b = y;  end
                3'd1:    begin o_mul_a = r1; o_mul_b = a;  end
                3'd2:    begin o_mul_a = r2; o_mul_b = a;  end
                3'd3:    begin o_mul_a = r1; o_mul_b = x;  end
                3'd4:    begin o_mul_a = d;  o_mul_b = d;  end
                3'd5:    begin o_mul_a = d;  o_mul_b = r1; end
                3'd6:    begin o_mul_a = r1; o_mul_b = z;  end
                default: begin o_mul_a = '0; o_mul_b = '0; end
            endcase
        end
    end

    assign o_pt = {x3, y3, z3};

    // X3 = E - 2B, needed both for X3 and for R1 = B - X3 in the same post step
    always_comb begin
        x3_new = mod_sub(res, mod_dbl(b));
    end

    // Step counter and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step <= '0;
            x3   <= '0;
            y3   <= '0;
            z3   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_val) begin
                        step <= '0;
`ifdef EC_DBL_ZERO_BYPASS_EN
                        if (zin_zero) begin
                            x3 <= i_pt[3*W-1 -: W];
                            y3 <= i_pt[2*W-1 -: W];
                            z3 <= i_pt[W-1:0];
                        end
`endif
                    end
                end
                POST: begin
                    step <= step + 3'd1;
                    case (step)
                        3'd4:    x3 <= x3_new;
                        3'd5:    y3 <= mod_sub(res, c);
                        3'd6:    z3 <= res;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Operand and intermediate registers (no reset needed: written before use)
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_val) begin
            x <= i_pt[3*W-1 -: W];
            y <= i_pt[2*W-1 -: W];
            z <= i_pt[W-1:0];
        end
        if (state == WAIT && i_mul_val)
            res <= i_mul_c;
        if (state == POST) begin
            case (step)
                3'd0: begin
                    a  <= res;
                    r1 <= mod_dbl(mod_dbl(x));
                    r2 <= mod_dbl(mod_dbl(mod_dbl(res)));
                end
                3'd1: b <= res;
                3'd2: begin
                    c  <= res;
                    r1 <= mod_add(mod_dbl(x), x);
                end
                3'd3: d  <= res;
                3'd4: r1 <= mod_sub(b, x3_new);
                3'd5: r1 <= mod_dbl(y);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_jb_point_dbl_seq.sv
module tb_ec_jb_point_dbl_seq;

    localparam int unsigned W = 381;
    localparam logic [W-1:0] P  = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam logic [W-1:0] GX = 381'h17f1d3a73197d7942695638c4fa9ac0fc3688c4f9774b905a14e3a3f171bac586c55e83ff97a1aeffb3af00adb22c6bb;
    localparam logic [W-1:0] GY = 381'h08b3f481e3aaa0f1a09e30ed741d8ae4fcf5e095d5d00af600db18cb2c04b3edd03cc744a2888ae40caa232946c5e7e1;

    logic             i_clk, i_rst, i_val, o_rdy, o_val, i_rdy;
    logic [3*W-1:0]   i_pt, o_pt;
    logic [W-1:0]     o_mul_a, o_mul_b, i_mul_c;
    logic             o_mul_val, i_mul_rdy, i_mul_val;

    int npass = 0;
    int ntotal = 0;

    ec_jb_point_dbl_seq #(.DAT_BITS(W), .P(P)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pt(i_pt), .i_val(i_val), .o_rdy(o_rdy),
        .o_pt(o_pt), .o_val(o_val), .i_rdy(i_rdy), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy), .i_mul_c(i_mul_c), .i_mul_val(i_mul_val)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- field arithmetic reference ----------------
    function automatic logic [W-1:0] fm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] t;
        t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(t % {{W{1'b0}}, P});
    endfunction

    function automatic logic [W-1:0] fa(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        return W'(t % {1'b0, P});
    endfunction

    function automatic logic [W-1:0] fs(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return W'(t % {1'b0, P});
    endfunction

    function automatic logic [W-1:0] finv(input logic [W-1:0] a);
        logic [W-1:0] r, e;
        r = W'(1);
        e = P - W'(2);
        for (int i = W - 1; i >= 0; i--) begin
            r = fm(r, r);
            if (e[i]) r = fm(r, a);
        end
        return r;
    endfunction

    // Jacobian doubling for a=0, written directly from the formulas
    function automatic logic [3*W-1:0] jdbl(input logic [3*W-1:0] pt);
        logic [W-1:0] x, y, z, ca, cb, cc, cd, x3, y3, z3;
        x  = pt[3*W-1 -: W];
        y  = pt[2*W-1 -: W];
        z  = pt[W-1:0];
        ca = fm(y, y);
        cb = fm(fm(W'(4), x), ca);
        cc = fm(W'(8), fm(ca, ca));
        cd = fm(W'(3), fm(x, x));
        x3 = fs(fm(cd, cd), fm(W'(2), cb));
        y3 = fs(fm(cd, fs(cb, x3)), cc);
        z3 = fm(W'(2), fm(y, z));
        return {x3, y3, z3};
    endfunction

    function automatic logic [W-1:0] rnd_fe();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom)};
        return W'(r % {3'b000, P});
    endfunction

    // ---------------- multiplier model and monitor ----------------
    int            cyc = 0;
    int            mul_lat = 1;
    bit            rnd_rdy = 1'b0;
    int            nmul = 0;
    int            nstall = 0;
    int            stall_viol = 0;
    bit            stall_prev = 1'b0;
    logic [W-1:0]  sa, sb;
    logic [W-1:0]  mq_d[$];
    int            mq_due[$];

    always @(posedge i_clk) begin
        cyc = cyc + 1;
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !(o_mul_val && o_mul_a === sa && o_mul_b === sb))
                stall_viol = stall_viol + 1;
            if (o_mul_val && i_mul_rdy) begin
                mq_d.push_back(fm(o_mul_a, o_mul_b));
                mq_due.push_back(cyc + mul_lat);
                nmul = nmul + 1;
            end
            stall_prev = o_mul_val && !i_mul_rdy;
            if (stall_prev) nstall = nstall + 1;
            sa = o_mul_a;
            sb = o_mul_b;
        end
    end

    always @(negedge i_clk) begin
        i_mul_rdy = rnd_rdy ? 1'($urandom % 2) : 1'b1;
        i_mul_val = 1'b0;
        if (mq_d.size() > 0 && mq_due[0] <= cyc + 1) begin
            i_mul_val = 1'b1;
            i_mul_c   = mq_d.pop_front();
            void'(mq_due.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic start_op(input logic [3*W-1:0] pt);
        int g;
        nmul = 0;
        @(negedge i_clk);
        i_pt  = pt;
        i_val = 1'b1;
        g = 0;
        while (!o_rdy && g < 100) begin @(negedge i_clk); g++; end
        @(posedge i_clk);
        @(negedge i_clk);
        i_val = 1'b0;
    endtask

    // Runs one doubling; lat = edge index (from accept) at which the output handshake can occur
    task automatic run_op(input logic [3*W-1:0] pt, output logic [3*W-1:0] res, output int lat);
        start_op(pt);
        lat = 0;
        while (!o_val && lat < 3000) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
        end
        lat = lat + 1;
        res = o_pt;
    endtask

    task automatic finish_op();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        ntotal++; if (o_rdy !== 1'b1) $display("FAIL reset_rdy got=%b exp=1", o_rdy); else npass++;
        ntotal++; if (o_val !== 1'b0) $display("FAIL reset_val got=%b exp=0", o_val); else npass++;
        ntotal++; if (o_mul_val !== 1'b0) $display("FAIL reset_mul_val got=%b exp=0", o_mul_val); else npass++;
        ntotal++; if (o_pt !== '0) $display("FAIL reset_pt got=%h exp=0", o_pt); else npass++;
    endtask

    task automatic test_generator();
        logic [3*W-1:0] pt, res, exp;
        int lat;
        mul_lat = 1; rnd_rdy = 1'b0;
        pt  = {GX, GY, W'(1)};
        exp = jdbl(pt);
        run_op(pt, res, lat);
        ntotal++; if (lat !== 22) $display("FAIL gen_latency got=%0d exp=22", lat); else npass++;
        ntotal++; if (res !== exp) $display("FAIL gen_result got=%h exp=%h", res, exp); else npass++;
        ntotal++; if (nmul !== 7) $display("FAIL gen_mul_count got=%0d exp=7", nmul); else npass++;
        finish_op();
        ntotal++; if ({o_rdy, o_val} !== 2'b10) $display("FAIL gen_release got=%b exp=10", {o_rdy, o_val}); else npass++;
    endtask

    task automatic test_chain();
        logic [3*W-1:0] p, m, res;
        logic [W-1:0]   ax, ay, l, nx, ny, zz;
        int lat;
        mul_lat = 1; rnd_rdy = 1'b0;
        p = {GX, GY, W'(1)};
        m = p;
        for (int k = 0; k < 8; k++) begin
            m = jdbl(m);
            run_op(p, res, lat);
            finish_op();
            ntotal++; if (res !== m) $display("FAIL chain_%0d got=%h exp=%h", k, res, m); else npass++;
            p = res;
        end
        // independent affine doubling chain to 256G
        ax = GX; ay = GY;
        for (int k = 0; k < 8; k++) begin
            l  = fm(fm(W'(3), fm(ax, ax)), finv(fm(W'(2), ay)));
            nx = fs(fm(l, l), fm(W'(2), ax));
            ny = fs(fm(l, fs(ax, nx)), ay);
            ax = nx; ay = ny;
        end
        zz = fm(p[W-1:0], p[W-1:0]);
        ntotal++; if (p[3*W-1 -: W] !== fm(ax, zz)) $display("FAIL chain_affine_x got=%h exp=%h", p[3*W-1 -: W], fm(ax, zz)); else npass++;
        ntotal++; if (p[2*W-1 -: W] !== fm(ay, fm(zz, p[W-1:0]))) $display("FAIL chain_affine_y got=%h exp=%h", p[2*W-1 -: W], fm(ay, fm(zz, p[W-1:0]))); else npass++;
    endtask

    task automatic test_backpressure();
        logic [3*W-1:0] pt, res, exp;
        int lat;
        mul_lat = 1; rnd_rdy = 1'b0;
        pt  = {rnd_fe(), rnd_fe(), rnd_fe()};
        exp = jdbl(pt);
        i_rdy = 1'b0;
        run_op(pt, res, lat);
        ntotal++; if (res !== exp) $display("FAIL bp_result got=%h exp=%h", res, exp); else npass++;
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            ntotal++;
            if ({o_val, o_rdy, o_pt} !== {1'b1, 1'b0, exp})
                $display("FAIL bp_hold_%0d got val=%b rdy=%b exp val=1 rdy=0", k, o_val, o_rdy);
            else npass++;
        end
        i_rdy = 1'b1;
        finish_op();
        ntotal++; if ({o_rdy, o_val} !== 2'b10) $display("FAIL bp_release got=%b exp=10", {o_rdy, o_val}); else npass++;
    endtask

    task automatic test_mult_stall();
        logic [3*W-1:0] pt, res, exp;
        int lat;
        mul_lat = 5; rnd_rdy = 1'b1;
        stall_viol = 0; nstall = 0;
        for (int k = 0; k < 3; k++) begin
            pt  = {rnd_fe(), rnd_fe(), rnd_fe()};
            exp = jdbl(pt);
            run_op(pt, res, lat);
            finish_op();
            ntotal++; if (res !== exp) $display("FAIL stall_result_%0d got=%h exp=%h", k, res, exp); else npass++;
        end
        rnd_rdy = 1'b0;
        ntotal++; if (stall_viol !== 0) $display("FAIL stall_operand_change got=%0d exp=0", stall_viol); else npass++;
        ntotal++; if (nstall == 0) $display("FAIL stall_seen got=%0d exp=>0", nstall); else npass++;
        pt = {rnd_fe(), rnd_fe(), W'(1)};
        run_op(pt, res, lat);
        finish_op();
        ntotal++; if (lat !== 50) $display("FAIL latency_l5 got=%0d exp=50", lat); else npass++;
        ntotal++; if (res !== jdbl(pt)) $display("FAIL latency_l5_result got=%h exp=%h", res, jdbl(pt)); else npass++;
    endtask

    task automatic test_zero();
        logic [3*W-1:0] pt, res;
        int lat;
        mul_lat = 1; rnd_rdy = 1'b0;
        pt = {W'(1), W'(1), W'(0)};
        run_op(pt, res, lat);
`ifdef EC_DBL_ZERO_BYPASS_EN
        ntotal++; if (lat !== 1) $display("FAIL zero_latency got=%0d exp=1", lat); else npass++;
        ntotal++; if (res !== pt) $display("FAIL zero_result got=%h exp=%h", res, pt); else npass++;
        ntotal++; if (nmul !== 0) $display("FAIL zero_mul_count got=%0d exp=0", nmul); else npass++;
`else
        ntotal++; if (lat !== 22) $display("FAIL zero_latency got=%0d exp=22", lat); else npass++;
        ntotal++; if (res !== jdbl(pt)) $display("FAIL zero_result got=%h exp=%h", res, jdbl(pt)); else npass++;
        ntotal++; if (res[W-1:0] !== '0) $display("FAIL zero_z3 got=%h exp=0", res[W-1:0]); else npass++;
`endif
        finish_op();
    endtask

    task automatic test_reset_mid();
        logic [3*W-1:0] pt, res;
        int lat, g;
        bit bad;
        mul_lat = 3; rnd_rdy = 1'b0;
        start_op({rnd_fe(), rnd_fe(), W'(1)});
        g = 0;
        while (nmul < 4 && g < 200) begin @(negedge i_clk); g++; end
        ntotal++; if (nmul !== 4) $display("FAIL rst_mid_reach got=%0d exp=4", nmul); else npass++;
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        ntotal++; if ({o_rdy, o_val, o_mul_val} !== 3'b100) $display("FAIL rst_mid_state got=%b exp=100", {o_rdy, o_val, o_mul_val}); else npass++;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (!o_rdy || o_val || o_mul_val) bad = 1'b1;
        end
        ntotal++; if (bad !== 1'b0) $display("FAIL rst_mid_stray got=%b exp=0", bad); else npass++;
        mul_lat = 1;
        pt = {rnd_fe(), rnd_fe(), rnd_fe()};
        run_op(pt, res, lat);
        finish_op();
        ntotal++; if (res !== jdbl(pt)) $display("FAIL rst_mid_new_op got=%h exp=%h", res, jdbl(pt)); else npass++;
        ntotal++; if (lat !== 22) $display("FAIL rst_mid_latency got=%0d exp=22", lat); else npass++;
    endtask

    task automatic test_edge();
        logic [3*W-1:0] pt, res;
        int lat;
        mul_lat = 1; rnd_rdy = 1'b0;
        pt = {P - W'(1), P - W'(1), W'(1)};
        run_op(pt, res, lat);
        finish_op();
        ntotal++; if (res !== jdbl(pt)) $display("FAIL edge_result got=%h exp=%h", res, jdbl(pt)); else npass++;
        ntotal++;
        if (!(res[3*W-1 -: W] < P && res[2*W-1 -: W] < P && res[W-1:0] < P))
            $display("FAIL edge_range got=%h exp=coords<P", res);
        else npass++;
    endtask

    initial begin
        i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b1; i_pt = '0;
        i_mul_val = 1'b0; i_mul_c = '0; i_mul_rdy = 1'b1;
        test_reset();
        test_generator();
        test_chain();
        test_backpressure();
        test_mult_stall();
        test_zero();
        test_reset_mid();
        test_edge();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
